// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle for sync_fifo_param.
//   master : producer/consumer side (drives wr_en, wr_data, rd_en, err_clr)
//   slave  : FIFO side (drives rd_data, status flags, count, error flags)
// Ports carried: wr_en, wr_data, rd_en, rd_data, full, empty, almost_full,
//   almost_empty, count, err_clr, overflow, underflow.
interface sync_fifo_param_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  err_clr;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// almost-full/almost-empty thresholds, occupancy count and sticky error flags.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset, overrides every other input
//   bus : sync_fifo_param_if.slave (write/read handshake, status, error flags)
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned FWFT          = 0,
    parameter int unsigned AFULL_THRESH  = 12,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_param_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_ok, wr_ok;

    // A read on a full FIFO frees a slot in the same cycle, so the write may proceed.
    assign rd_ok = bus.rd_en && !bus.empty;
    assign wr_ok = bus.wr_en && (!bus.full || rd_ok);

    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (!wr_ok && rd_ok) begin
            count_d = count_q - 1'b1;
        end
        // Set condition wins over err_clr.
        overflow_d  = (overflow_q && !bus.err_clr) || (bus.wr_en && !wr_ok);
        underflow_d = (underflow_q && !bus.err_clr) || (bus.rd_en && bus.empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; the write is still suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; meaningless while empty.
            assign bus.rd_data = mem[rd_ptr_q];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q <= '0;
                end else if (rd_ok) begin
                    rd_data_q <= mem[rd_ptr_q];
                end
            end
            assign bus.rd_data = rd_data_q;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.full         = (count_q == DEPTH_C);
    assign bus.empty        = (count_q == '0);
    assign bus.almost_full  = (count_q >= AFULL_C);
    assign bus.almost_empty = (count_q <= AEMPTY_C);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_std ();
    sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_fw ();

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0),
                      .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_std (
        .clk (clk),
        .rst (rst),
        .bus (bus_std)
    );

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1),
                      .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_fw (
        .clk (clk),
        .rst (rst),
        .bus (bus_fw)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: scoreboard queue of stored words plus expected flags.
    logic [7:0] sb[$];
    int         mdl_count   = 0;
    bit         mdl_ovf     = 1'b0;
    bit         mdl_udf     = 1'b0;
    logic [7:0] mdl_rd_data = 8'h00;

    // Drives one cycle on both FIFOs, updates the model, returns #1 after the edge.
    task automatic drive_cycle(input bit wr, input logic [7:0] d, input bit rd,
                               input bit clr, input bit rs);
        bit rd_ok, wr_ok, was_empty;
        bus_std.wr_en = wr; bus_std.wr_data = d; bus_std.rd_en = rd; bus_std.err_clr = clr;
        bus_fw.wr_en  = wr; bus_fw.wr_data  = d; bus_fw.rd_en  = rd; bus_fw.err_clr  = clr;
        rst = rs;
        if (rs) begin
            sb.delete();
            mdl_count = 0; mdl_ovf = 1'b0; mdl_udf = 1'b0; mdl_rd_data = 8'h00;
        end else begin
            was_empty = (mdl_count == 0);
            rd_ok = rd && !was_empty;
            wr_ok = wr && ((mdl_count != DEPTH) || rd_ok);
            if (rd_ok) mdl_rd_data = sb.pop_front();
            if (wr_ok) sb.push_back(d);
            mdl_count = mdl_count + int'(wr_ok) - int'(rd_ok);
            mdl_ovf = (mdl_ovf && !clr) || (wr && !wr_ok);
            mdl_udf = (mdl_udf && !clr) || (rd && was_empty);
        end
        @(posedge clk);
        #1;
        bus_std.wr_en = 1'b0; bus_std.rd_en = 1'b0; bus_std.err_clr = 1'b0;
        bus_fw.wr_en  = 1'b0; bus_fw.rd_en  = 1'b0; bus_fw.err_clr  = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_cycle(0, 8'h00, 0, 0, 1);
        drive_cycle(0, 8'h00, 0, 0, 1);
        checks++; if (bus_std.count !== 5'd0) begin errors++;
            $display("FAIL reset_count: got %0d expected 0", bus_std.count); end
        checks++; if (bus_std.empty !== 1'b1 || bus_std.full !== 1'b0) begin errors++;
            $display("FAIL reset_empty_full: got %b%b expected 10", bus_std.empty, bus_std.full); end
        checks++; if (bus_std.almost_empty !== 1'b1 || bus_std.almost_full !== 1'b0) begin errors++;
            $display("FAIL reset_almost: got ae=%b af=%b expected ae=1 af=0",
                     bus_std.almost_empty, bus_std.almost_full); end
        checks++; if (bus_std.overflow !== 1'b0 || bus_std.underflow !== 1'b0) begin errors++;
            $display("FAIL reset_err: got ovf=%b udf=%b expected 0 0",
                     bus_std.overflow, bus_std.underflow); end
        checks++; if (bus_std.rd_data !== 8'h00) begin errors++;
            $display("FAIL reset_rd_data: got %h expected 00", bus_std.rd_data); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1, 8'(i), 0, 0, 0);
            checks++; if (bus_std.count !== 5'(i + 1) || mdl_count != i + 1) begin errors++;
                $display("FAIL fill_count[%0d]: got %0d expected %0d", i, bus_std.count, i + 1); end
            checks++; if (bus_std.empty !== 1'b0) begin errors++;
                $display("FAIL fill_empty[%0d]: got %b expected 0", i, bus_std.empty); end
            checks++; if (bus_std.almost_empty !== ((i + 1) <= 2)) begin errors++;
                $display("FAIL fill_aempty[%0d]: got %b expected %b", i,
                         bus_std.almost_empty, ((i + 1) <= 2)); end
            checks++; if (bus_std.almost_full !== ((i + 1) >= 12)) begin errors++;
                $display("FAIL fill_afull[%0d]: got %b expected %b", i,
                         bus_std.almost_full, ((i + 1) >= 12)); end
            checks++; if (bus_std.full !== ((i + 1) == DEPTH)) begin errors++;
                $display("FAIL fill_full[%0d]: got %b expected %b", i,
                         bus_std.full, ((i + 1) == DEPTH)); end
            checks++; if (bus_fw.rd_data !== sb[0]) begin errors++;
                $display("FAIL fill_fwft_head[%0d]: got %h expected %h", i, bus_fw.rd_data, sb[0]); end
        end
    endtask

    task automatic test_overflow_full();
        drive_cycle(1, 8'hAA, 0, 0, 0);
        checks++; if (bus_std.overflow !== 1'b1 || bus_fw.overflow !== 1'b1) begin errors++;
            $display("FAIL ovf_set: got %b/%b expected 1", bus_std.overflow, bus_fw.overflow); end
        checks++; if (bus_std.count !== 5'd16) begin errors++;
            $display("FAIL ovf_count: got %0d expected 16", bus_std.count); end
        drive_cycle(1, 8'hBB, 1, 0, 0);
        checks++; if (bus_std.count !== 5'd16 || bus_std.full !== 1'b1) begin errors++;
            $display("FAIL full_rw: got count=%0d full=%b expected 16 1",
                     bus_std.count, bus_std.full); end
        checks++; if (bus_std.rd_data !== 8'h00) begin errors++;
            $display("FAIL full_rw_data: got %h expected 00", bus_std.rd_data); end
        checks++; if (bus_fw.rd_data !== 8'h01) begin errors++;
            $display("FAIL full_rw_fwft: got %h expected 01", bus_fw.rd_data); end
    endtask

    task automatic test_drain_std();
        logic [7:0] want;
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(0, 8'h00, 1, 0, 0);
            want = (i < 15) ? 8'(i + 1) : 8'hBB;
            checks++; if (bus_std.rd_data !== want || mdl_rd_data !== want) begin errors++;
                $display("FAIL drain_data[%0d]: got %h expected %h", i, bus_std.rd_data, want); end
            if (sb.size() > 0) begin
                checks++; if (bus_fw.rd_data !== sb[0]) begin errors++;
                    $display("FAIL drain_fwft[%0d]: got %h expected %h", i, bus_fw.rd_data, sb[0]); end
            end
        end
        checks++; if (bus_std.empty !== 1'b1 || bus_std.count !== 5'd0) begin errors++;
            $display("FAIL drain_empty: got empty=%b count=%0d expected 1 0",
                     bus_std.empty, bus_std.count); end
        checks++; if (bus_std.underflow !== 1'b0) begin errors++;
            $display("FAIL drain_udf_pre: got %b expected 0", bus_std.underflow); end
        drive_cycle(0, 8'h00, 1, 0, 0);
        checks++; if (bus_std.underflow !== 1'b1 || bus_std.rd_data !== 8'hBB) begin errors++;
            $display("FAIL drain_udf: got udf=%b data=%h expected 1 bb",
                     bus_std.underflow, bus_std.rd_data); end
        checks++; if (bus_std.count !== 5'd0) begin errors++;
            $display("FAIL drain_udf_count: got %0d expected 0", bus_std.count); end
    endtask

    task automatic test_fwft();
        drive_cycle(0, 8'h00, 0, 1, 0);
        drive_cycle(1, 8'h5A, 0, 0, 0);
        checks++; if (bus_fw.rd_data !== 8'h5A) begin errors++;
            $display("FAIL fwft_first: got %h expected 5a", bus_fw.rd_data); end
        drive_cycle(1, 8'h3C, 0, 0, 0);
        checks++; if (bus_fw.rd_data !== 8'h5A || bus_fw.count !== 5'd2) begin errors++;
            $display("FAIL fwft_hold: got %h/%0d expected 5a/2", bus_fw.rd_data, bus_fw.count); end
        drive_cycle(0, 8'h00, 1, 0, 0);
        checks++; if (bus_fw.rd_data !== 8'h3C) begin errors++;
            $display("FAIL fwft_pop1: got %h expected 3c", bus_fw.rd_data); end
        checks++; if (bus_std.rd_data !== 8'h5A) begin errors++;
            $display("FAIL std_pop1: got %h expected 5a", bus_std.rd_data); end
        drive_cycle(0, 8'h00, 1, 0, 0);
        checks++; if (bus_fw.empty !== 1'b1 || bus_std.rd_data !== 8'h3C) begin errors++;
            $display("FAIL fwft_pop2: got empty=%b std=%h expected 1 3c",
                     bus_fw.empty, bus_std.rd_data); end
    endtask

    task automatic test_empty_rw();
        drive_cycle(1, 8'h77, 1, 0, 0);
        checks++; if (bus_std.underflow !== 1'b1 || bus_std.count !== 5'd1) begin errors++;
            $display("FAIL empty_rw: got udf=%b count=%0d expected 1 1",
                     bus_std.underflow, bus_std.count); end
        checks++; if (bus_fw.rd_data !== 8'h77) begin errors++;
            $display("FAIL empty_rw_fwft: got %h expected 77", bus_fw.rd_data); end
        drive_cycle(0, 8'h00, 1, 0, 0);
        checks++; if (bus_std.rd_data !== mdl_rd_data || mdl_rd_data !== 8'h77) begin errors++;
            $display("FAIL empty_rw_read: got %h expected 77", bus_std.rd_data); end
        drive_cycle(0, 8'h00, 1, 1, 0);
        checks++; if (bus_std.underflow !== 1'b1) begin errors++;
            $display("FAIL clr_set_wins: got %b expected 1", bus_std.underflow); end
        drive_cycle(0, 8'h00, 0, 1, 0);
        checks++; if (bus_std.underflow !== 1'b0 || bus_std.overflow !== 1'b0) begin errors++;
            $display("FAIL err_clr: got udf=%b ovf=%b expected 0 0",
                     bus_std.underflow, bus_std.overflow); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive_cycle(1, 8'(8'h20 + i), 0, 0, 0);
        drive_cycle(0, 8'h00, 1, 0, 0);
        drive_cycle(1, 8'h30, 0, 0, 0);
        checks++; if (bus_std.count !== 5'd5 || mdl_count != 5) begin errors++;
            $display("FAIL mid_pre: got %0d expected 5", bus_std.count); end
        drive_cycle(1, 8'hEE, 0, 0, 1);
        checks++; if (bus_std.count !== 5'd0 || bus_std.empty !== 1'b1) begin errors++;
            $display("FAIL mid_rst: got count=%0d empty=%b expected 0 1",
                     bus_std.count, bus_std.empty); end
        checks++; if (bus_std.overflow !== 1'b0 || bus_std.underflow !== 1'b0
                      || bus_std.rd_data !== 8'h00) begin errors++;
            $display("FAIL mid_rst_flags: got ovf=%b udf=%b data=%h expected 0 0 00",
                     bus_std.overflow, bus_std.underflow, bus_std.rd_data); end
        drive_cycle(1, 8'h11, 0, 0, 0);
        checks++; if (bus_fw.rd_data !== 8'h11 || bus_fw.count !== 5'd1) begin errors++;
            $display("FAIL mid_fresh: got %h/%0d expected 11/1", bus_fw.rd_data, bus_fw.count); end
        drive_cycle(0, 8'h00, 1, 0, 0);
        checks++; if (bus_std.rd_data !== 8'h11) begin errors++;
            $display("FAIL mid_fresh_std: got %h expected 11", bus_std.rd_data); end
    endtask

    initial begin
        bus_std.wr_en = 1'b0; bus_std.wr_data = 8'h00; bus_std.rd_en = 1'b0; bus_std.err_clr = 1'b0;
        bus_fw.wr_en  = 1'b0; bus_fw.wr_data  = 8'h00; bus_fw.rd_en  = 1'b0; bus_fw.err_clr  = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_overflow_full();
        test_drain_std();
        test_fwft();
        test_empty_rw();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO: the same-domain successor to our dual-clock async_fifo, for buffering where writer and reader share one clock. Adds configurable depth and width, standard or first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. Sits between producer and consumer logic in one clock domain.

Parameters:
DATA_WIDTH, 8, width of each stored word.
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH entries.
FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency); 1 = first-word-fall-through.
AFULL_THRESH, 12, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.
AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH; legal range 0..DEPTH-1.

Ports:
clk  input  1  single clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
wr_en  input  1  write request.
wr_data  input  DATA_WIDTH  write data, sampled when a write is accepted.
rd_en  input  1  read request (standard mode) / pop acknowledge (FWFT).
rd_data  output  DATA_WIDTH  read data.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AFULL_THRESH.
almost_empty  output  1  count <= AEMPTY_THRESH.
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
err_clr  input  1  clears overflow and underflow.
overflow  output  1  sticky: a write was rejected.
underflow  output  1  sticky: a read was rejected.

Behaviour:
- One clock, clk; reset synchronous, active-high, on rst. rst has priority over all other inputs in the same cycle.
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, rd_data = 0 (standard mode). Memory array is not reset.
- Reset mid-operation: all stored data is discarded; the next cycle looks like a fresh empty FIFO.
- rd_ok = rd_en && !empty.
- wr_ok = wr_en && (!full || rd_ok). When full, a simultaneous read makes room, so both are accepted.
- When empty, a simultaneous read and write gives: read rejected (underflow set), write accepted.
- Accepted write: mem[wr_ptr] <= wr_data, and wr_ptr increments.
- Accepted read: rd_ptr increments.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH naturally.
- count_next = count + wr_ok - rd_ok. All flags are derived from the registered count.
- Flags update at the same edge as the accepted operation. A write at edge N clears empty after edge N.
- Standard mode (FWFT=0):
  - rd_data <= mem[rd_ptr] at an edge with rd_ok, so data is valid the cycle after rd_en.
  - rd_data holds its value otherwise, including during rejected reads.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] continuously while !empty; the head word is visible the cycle after its write edge.
  - rd_en with !empty pops the head, and the next word appears after that edge.
  - rd_data is don't-care while empty.
- overflow sets on wr_en && !wr_ok. underflow sets on rd_en && empty.
- err_clr clears both error flags. If a set condition and err_clr occur in the same cycle, the set wins.
- Rejected operations never modify pointers, count or memory.

Test Plan:
- Reset then fill: rst for 2 cycles, then 16 writes of 0x00..0x0F in consecutive cycles. Required: count steps 0->16; almost_empty deasserts when count reaches 3; almost_full asserts at count 12; full = 1 at 16; empty = 0 from the first write edge.
- Overflow and simultaneous access when full: a 17th write (0xAA) alone gives overflow = 1 and count stays 16. Then wr_en + rd_en together with data 0xBB: both accepted, count stays 16, full stays 1, 0xBB lands in the slot after 0x0F.
- Standard-mode drain and wrap: FWFT=0, read 16 times. Required: rd_data = 0x01..0x0F, then 0xBB, each one cycle after rd_en. Then empty = 1, count = 0; another rd_en sets underflow and rd_data holds 0xBB.
- FWFT mode: FWFT=1, write 0x5A then 0x3C. Required: rd_data = 0x5A the cycle after the first write, with no rd_en. After one pop, rd_data = 0x3C; after the second pop, empty = 1.
- Empty with simultaneous read+write: with count 0, assert wr_en (0x77) and rd_en together. Required: underflow = 1, count = 1, and a later read returns 0x77. err_clr asserted alone clears both error flags the next cycle.
- Reset mid-operation: with count 5, assert rst for one cycle alongside wr_en. Required: count = 0, empty = 1, no write recorded, error flags 0.
